// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// write-back source encodings, architectural constants and instruction helpers.
package id_ex_pipe_pkg;

  localparam int unsigned CTRL_W = 13;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // Bundle bit offsets, MSB..LSB; bit 12 is a spare slot carried through untouched.
  localparam int unsigned CTRL_REGDST     = 11;
  localparam int unsigned CTRL_ALUSRCB    = 10;
  localparam int unsigned CTRL_DTR_LSB    = 8;
  localparam int unsigned CTRL_JAL        = 7;
  localparam int unsigned CTRL_BRANCH_LSB = 5;
  localparam int unsigned CTRL_REGWRITE   = 4;
  localparam int unsigned CTRL_MEMW       = 3;
  localparam int unsigned CTRL_ALU_LSB    = 0;

  typedef enum logic [1:0] {
    DTR_ALU  = 2'b00,
    DTR_MEM  = 2'b01,
    DTR_LUI  = 2'b10,
    DTR_LINK = 2'b11
  } dtr_e;

  localparam logic [4:0] REG_RA = 5'd31;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] lo;
  } id_fields_t;

  function automatic id_fields_t split_inst(input logic [31:0] inst);
    id_fields_t f;
    f.op = inst[31:26];
    f.rs = inst[25:21];
    f.rt = inst[20:16];
    f.rd = inst[15:11];
    f.lo = inst[10:0];
    return f;
  endfunction

  // Logical ops zero-extend, lui shifts into the upper half, all else sign-extends.
  function automatic logic [31:0] ext_imm(input id_fields_t f);
    logic [15:0] imm;
    imm = {f.rd, f.lo};
    case (f.op)
      OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
      OP_LUI:                   return {imm, 16'h0000};
      default:                  return {{16{imm[15]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// Bus between the ID stage, the ID/EX register and the EX stage.
interface id_ex_pipe_if;
  import id_ex_pipe_pkg::*;

  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       id_inst;
  logic [31:0]       id_pc;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic              MIO_ready;
  logic              flush;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_inst;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_rs_data;
  logic [31:0]       ex_rt_data;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_wreg;
  logic              stall;
  logic [15:0]       bubble_cnt;

  modport slave (
    input  id_ctrl, id_inst, id_pc, id_rs_data, id_rt_data, MIO_ready, flush,
    output ex_ctrl, ex_inst, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_wreg,
           stall, bubble_cnt
  );

  modport master (
    output id_ctrl, id_inst, id_pc, id_rs_data, id_rt_data, MIO_ready, flush,
    input  ex_ctrl, ex_inst, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_wreg,
           stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import id_ex_pipe_pkg::*;
(
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic [1:0] ex_dtr_i,
  input  logic       ex_regwrite_i,
  input  logic [4:0] ex_wreg_i,
  input  logic       id_regdst_i,
  input  logic       id_memw_i,
  input  logic [5:0] id_op_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       stall_o
);

  logic ex_is_load;
  logic rt_used;
  logic match_rs;
  logic match_rt;

  assign ex_is_load = (ex_dtr_i == DTR_MEM) && ex_regwrite_i && (ex_wreg_i != '0);
  assign rt_used    = id_regdst_i || id_memw_i || (id_op_i == OP_BEQ) || (id_op_i == OP_BNE);
  assign match_rs   = (ex_wreg_i == id_rs_i);
  assign match_rt   = rt_used && (ex_wreg_i == id_rt_i);

  // A squashed or reset ID instruction never needs to wait for the load.
  assign stall_o = !rst_i && !flush_i && ex_is_load && (match_rs || match_rt);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with freeze, flush, load-use bubble insertion and a
// saturating count of inserted load-use bubbles.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
(
  input logic         clk,
  input logic         rst,
  id_ex_pipe_if.slave bus
);

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [31:0]       ex_inst_q, ex_inst_d;
  logic [31:0]       ex_pc_q, ex_pc_d;
  logic [31:0]       ex_rs_q, ex_rs_d;
  logic [31:0]       ex_rt_q, ex_rt_d;
  logic [31:0]       ex_imm_q, ex_imm_d;
  logic [4:0]        ex_wreg_q, ex_wreg_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  id_fields_t id_f;
  logic       load_use;
  logic [4:0] id_wreg;

  assign id_f = split_inst(bus.id_inst);

  hazard_detect u_hazard (
    .rst_i         (rst),
    .flush_i       (bus.flush),
    .ex_dtr_i      (ex_ctrl_q[CTRL_DTR_LSB +: 2]),
    .ex_regwrite_i (ex_ctrl_q[CTRL_REGWRITE]),
    .ex_wreg_i     (ex_wreg_q),
    .id_regdst_i   (bus.id_ctrl[CTRL_REGDST]),
    .id_memw_i     (bus.id_ctrl[CTRL_MEMW]),
    .id_op_i       (id_f.op),
    .id_rs_i       (id_f.rs),
    .id_rt_i       (id_f.rt),
    .stall_o       (load_use)
  );

  always_comb begin
    id_wreg = id_f.rt;
    if (bus.id_ctrl[CTRL_JAL]) begin
      id_wreg = REG_RA;
    end else if (bus.id_ctrl[CTRL_REGDST]) begin
      id_wreg = id_f.rd;
    end
  end

  always_comb begin
    ex_ctrl_d    = ex_ctrl_q;
    ex_inst_d    = ex_inst_q;
    ex_pc_d      = ex_pc_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_imm_d     = ex_imm_q;
    ex_wreg_d    = ex_wreg_q;
    bubble_cnt_d = bubble_cnt_q;

    if (bus.MIO_ready) begin
      if (bus.flush || load_use) begin
        // load_use is already masked by flush, so only hazard bubbles are counted.
        ex_ctrl_d = CTRL_NOP;
        ex_inst_d = '0;
        ex_pc_d   = '0;
        ex_rs_d   = '0;
        ex_rt_d   = '0;
        ex_imm_d  = '0;
        ex_wreg_d = '0;
        if (load_use && (bubble_cnt_q != '1)) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end else begin
        ex_ctrl_d = bus.id_ctrl;
        ex_inst_d = bus.id_inst;
        ex_pc_d   = bus.id_pc;
        ex_rs_d   = bus.id_rs_data;
        ex_rt_d   = bus.id_rt_data;
        ex_imm_d  = ext_imm(id_f);
        ex_wreg_d = id_wreg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q    <= CTRL_NOP;
      ex_inst_q    <= '0;
      ex_pc_q      <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_imm_q     <= '0;
      ex_wreg_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_inst_q    <= ex_inst_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_imm_q     <= ex_imm_d;
      ex_wreg_q    <= ex_wreg_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_inst    = ex_inst_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_rs_data = ex_rs_q;
  assign bus.ex_rt_data = ex_rt_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_wreg    = ex_wreg_q;
  assign bus.stall      = load_use;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 id_ctrl  input  13  decoder bundle {RegDst,ALUSrc_B,DatatoReg[1:0],Jal,Branch[1:0],RegWrite,mem_w,ALU_Control[2:0]} packed MSB..LSB as listed (mem_w occupies the 1-bit MemRead/MemWrite slot pair collapsed; width fixed by package constant).
REQ-004 id_inst  input  32  ID-stage instruction word.
REQ-005 id_pc  input  32  ID-stage PC+4.
REQ-006 id_rs_data, id_rt_data  input  32 each  register-file read data.
REQ-007 MIO_ready  input  1  memory ready; low = freeze whole stage.
REQ-008 flush  input  1  EX branch/jump taken; squash ID instruction.
REQ-009 ex_ctrl  output  13  registered control bundle.
REQ-010 ex_inst, ex_pc, ex_rs_data, ex_rt_data, ex_imm  output  32 each  registered operands.
REQ-011 ex_wreg  output  5  registered destination register.
REQ-012 stall  output  1  combinational; hold PC and IF/ID register.
REQ-013 bubble_cnt  output  16  load-use bubble counter.

Function
REQ-014 Per-cycle priority SHALL be: rst > freeze (MIO_ready=0) > flush > load-use > normal capture.
REQ-015 Freeze: all registers, including bubble_cnt, SHALL hold value; stall SHALL still reflect current hazard.
REQ-016 Flush: next cycle ex_ctrl=0, ex_inst=0, ex_wreg=0, other data don't-care-but-zeroed; stall=0.
REQ-017 Load-use: ex_ctrl.DatatoReg=2'b01 AND ex_ctrl.RegWrite=1 AND ex_wreg!=0 AND (ex_wreg==id_inst[25:21] OR (rt_used AND ex_wreg==id_inst[20:16])).
REQ-018 rt_used SHALL be 1 when id RegDst=1, id mem_w=1, or id opcode is 6'b000100/6'b000101.
REQ-019 On load-use (no flush, MIO_ready=1): stall=1 same cycle; next cycle EX loads bubble (as REQ-016); bubble_cnt increments.
REQ-020 Hazard SHALL last exactly one cycle per load: the inserted bubble clears the load condition, so the held instruction captures normally next cycle.
REQ-021 Normal: capture all id_* inputs; latency one cycle.
REQ-022 ex_wreg = 5'd31 if Jal, else id_inst[15:11] if RegDst, else id_inst[20:16].
REQ-023 ex_imm = {16'b0,imm} for opcodes 001100/001101/001110; {imm,16'b0} for 001111; else sign-extend id_inst[15:0].
REQ-024 bubble_cnt SHALL saturate at 16'hFFFF; flush bubbles SHALL NOT count.
REQ-025 stall SHALL be 0 whenever flush=1 or rst=1.
REQ-026 id_inst=32'h00000000 passes as a NOP with ex_ctrl=0; no hazard raised by it.

Reset
REQ-027 On rst=1 at a clock edge: ex_ctrl, ex_inst, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_wreg, bubble_cnt SHALL become 0.
REQ-028 Reset asserted mid-stall SHALL override; first post-reset cycle captures id_* normally.

Structure
REQ-029 Shared package SHALL hold: CTRL_W=13, CTRL_NOP=0, bundle field offsets, DatatoReg encodings (ALU=00, MEM=01, LUI=10, LINK=11), REG_RA=31, opcodes BEQ/BNE/ANDI/ORI/XORI/LUI.
REQ-030 One sub-module, hazard_detect, SHALL contain the combinational load-use logic (REQ-017/018/025).

Verification
REQ-031 lw $2,0($1) then add $3,$2,$4 -> stall=1 one cycle, EX bubble (ex_ctrl=0), add enters EX next cycle, bubble_cnt=1.
REQ-032 lw $2 then add $3,$5,$6 -> stall never asserts, bubble_cnt=0.
REQ-033 lw $2 in EX, add using $2 in ID, flush=1 same cycle -> stall=0, ex_ctrl=0, bubble_cnt unchanged.
REQ-034 MIO_ready=0 for 3 cycles during load-use -> outputs held, stall=1 throughout, bubble_cnt increments once after MIO_ready=1.
REQ-035 id_inst=32'h3C01ABCD (lui), then 32'h3021FFFF (andi) -> ex_imm=32'hABCD0000 then 32'h0000FFFF; 32'h2021FFFF (addi) -> 32'hFFFFFFFF.
REQ-036 Force bubble_cnt path 65536 load-use events -> holds 16'hFFFF; rst=1 -> all outputs 0 next edge.
